// File: rtl/reg_bus_arb_pkg.sv
// ---------------------------------------------------------------------------
// reg_bus_arb_pkg
// Shared types and helpers for the register-bus round-robin arbiter.
//   arb_state_e : arbiter FSM state (IDLE, BUSY)
//   idx_width() : width of an index into n items, never less than 1 bit
// ---------------------------------------------------------------------------
package reg_bus_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_bus_rr_pick.sv
// ---------------------------------------------------------------------------
// reg_bus_rr_pick
// Combinational rotate-priority encoder. Returns the first set bit of req
// at or after position ptr, wrapping modulo NumReq.
// Ports:
//   req : request vector, NumReq bits
//   ptr : round-robin start position
//   idx : index of the selected request (0 when none set)
//   any : at least one request set
// ---------------------------------------------------------------------------
module reg_bus_rr_pick
   import reg_bus_arb_pkg::*;
#(
   parameter int unsigned NumReq = 4,
   localparam int unsigned IdxW = idx_width(NumReq)
) (
   input  logic [NumReq-1:0] req,
   input  logic [IdxW-1:0]   ptr,
   output logic [IdxW-1:0]   idx,
   output logic              any
);

   int              cand;
   logic [IdxW-1:0] cand_idx;

   // Scan offsets from the farthest to the nearest so the candidate closest
   // to ptr is the last one written and therefore wins.
   always_comb begin
      idx      = '0;
      any      = |req;
      cand     = 0;
      cand_idx = '0;
      for (int i = int'(NumReq) - 1; i >= 0; i--) begin
         cand = int'(ptr) + i;
         if (cand >= int'(NumReq)) cand = cand - int'(NumReq);
         cand_idx = IdxW'(cand);
         if (req[cand_idx]) idx = cand_idx;
      end
   end

endmodule

// File: rtl/reg_bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bus_rr_arbiter
// Round-robin arbiter sharing one register-bus target among NumReq
// requesters. One access at a time; the grant is held until the target
// answers with mgr_ready_i, then the FSM spends one IDLE cycle re-arbitrating.
//
// Optional watchdog: define REG_BUS_RR_ARBITER_TIMEOUT_EN to abort accesses
// that stay unanswered for TimeoutCycles BUSY cycles (error response and a
// timeout_o pulse). Without it a stalled target blocks the arbiter.
//
// Handshake: requester i holds req_valid_i[i] and its fields stable until
// req_ready_o[i] pulses; req_rdata_o/req_error_o are valid only in that
// cycle. Towards the target, mgr_valid_o is held with stable fields until
// mgr_ready_i is sampled high (or the watchdog/withdrawal ends the access).
//
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   req_valid/write/addr/wdata/wstrb_i : per-requester request fields
//   req_rdata/ready/error_o  : per-requester response
//   mgr_valid/write/addr/wdata/wstrb_o : request to the target
//   mgr_rdata/ready/error_i  : target response
//   timeout_o                : one-cycle pulse on watchdog abort
//   state_o                  : current FSM state (observability)
// ---------------------------------------------------------------------------
module reg_bus_rr_arbiter
   import reg_bus_arb_pkg::*;
#(
   parameter int unsigned NumReq        = 4,
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NumReq-1:0]                    req_valid_i,
   input  logic [NumReq-1:0]                    req_write_i,
   input  logic [NumReq-1:0][AddrWidth-1:0]     req_addr_i,
   input  logic [NumReq-1:0][DataWidth-1:0]     req_wdata_i,
   input  logic [NumReq-1:0][DataWidth/8-1:0]   req_wstrb_i,
   output logic [NumReq-1:0][DataWidth-1:0]     req_rdata_o,
   output logic [NumReq-1:0]                    req_ready_o,
   output logic [NumReq-1:0]                    req_error_o,
   output logic                                 mgr_valid_o,
   output logic                                 mgr_write_o,
   output logic [AddrWidth-1:0]                 mgr_addr_o,
   output logic [DataWidth-1:0]                 mgr_wdata_o,
   output logic [DataWidth/8-1:0]               mgr_wstrb_o,
   input  logic [DataWidth-1:0]                 mgr_rdata_i,
   input  logic                                 mgr_ready_i,
   input  logic                                 mgr_error_i,
   output logic                                 timeout_o,
   output arb_state_e                           state_o
);

   localparam int unsigned IdxW = idx_width(NumReq);

   arb_state_e      state_q, state_d;
   logic [IdxW-1:0] gnt_q, gnt_d;
   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [IdxW-1:0] ptr_adv;
   logic [IdxW-1:0] pick_idx;
   logic            pick_any;

`ifdef REG_BUS_RR_ARBITER_TIMEOUT_EN
   localparam int unsigned CntW = idx_width(TimeoutCycles);
   logic [CntW-1:0] cnt_q, cnt_d;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TimeoutCycles != 0);
`endif

   reg_bus_rr_pick #(
      .NumReq (NumReq)
   ) u_pick (
      .req (req_valid_i),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Next round-robin start: the requester after the one just served.
   assign ptr_adv = (gnt_q == IdxW'(NumReq - 1)) ? '0 : gnt_q + IdxW'(1);
   assign state_o = state_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
`ifdef REG_BUS_RR_ARBITER_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
`ifdef REG_BUS_RR_ARBITER_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      ptr_d       = ptr_q;
`ifdef REG_BUS_RR_ARBITER_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      mgr_valid_o = 1'b0;
      mgr_write_o = 1'b0;
      mgr_addr_o  = '0;
      mgr_wdata_o = '0;
      mgr_wstrb_o = '0;
      req_rdata_o = '0;
      req_ready_o = '0;
      req_error_o = '0;
      timeout_o   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               gnt_d   = pick_idx;
               state_d = BUSY;
`ifdef REG_BUS_RR_ARBITER_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end

         BUSY: begin
            mgr_valid_o = req_valid_i[gnt_q];
            mgr_write_o = req_write_i[gnt_q];
            mgr_addr_o  = req_addr_i[gnt_q];
            mgr_wdata_o = req_wdata_i[gnt_q];
            mgr_wstrb_o = req_wstrb_i[gnt_q];

            if (!req_valid_i[gnt_q]) begin
               // Requester withdrew: abandon silently, fairness pointer kept.
               state_d = IDLE;
            end else if (mgr_ready_i) begin
               req_ready_o[gnt_q] = 1'b1;
               req_error_o[gnt_q] = mgr_error_i;
               if (!req_write_i[gnt_q]) req_rdata_o[gnt_q] = mgr_rdata_i;
               ptr_d   = ptr_adv;
               state_d = IDLE;
            end
`ifdef REG_BUS_RR_ARBITER_TIMEOUT_EN
            else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
               // Withdraw from the target and answer the requester ourselves.
               mgr_valid_o        = 1'b0;
               req_ready_o[gnt_q] = 1'b1;
               req_error_o[gnt_q] = 1'b1;
               timeout_o          = 1'b1;
               ptr_d              = ptr_adv;
               state_d            = IDLE;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
`endif
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_reg_bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_bus_rr_arbiter
// Directed bench for reg_bus_rr_arbiter (NumReq=4, 32-bit, TimeoutCycles=8).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// Watchdog expectations follow REG_BUS_RR_ARBITER_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_reg_bus_rr_arbiter;
   import reg_bus_arb_pkg::*;

   logic                  clk;
   logic                  rst_n;
   logic [3:0]            req_valid;
   logic [3:0]            req_write;
   logic [3:0][31:0]      req_addr;
   logic [3:0][31:0]      req_wdata;
   logic [3:0][3:0]       req_wstrb;
   logic [3:0][31:0]      req_rdata;
   logic [3:0]            req_ready;
   logic [3:0]            req_error;
   logic                  mgr_valid;
   logic                  mgr_write;
   logic [31:0]           mgr_addr;
   logic [31:0]           mgr_wdata;
   logic [3:0]            mgr_wstrb;
   logic [31:0]           mgr_rdata;
   logic                  mgr_ready;
   logic                  mgr_error;
   logic                  timeout;
   arb_state_e            state;

   int total = 0;
   int bad   = 0;

   reg_bus_rr_arbiter #(
      .NumReq        (4),
      .AddrWidth     (32),
      .DataWidth     (32),
      .TimeoutCycles (8)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_write_i (req_write),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_wstrb_i (req_wstrb),
      .req_rdata_o (req_rdata),
      .req_ready_o (req_ready),
      .req_error_o (req_error),
      .mgr_valid_o (mgr_valid),
      .mgr_write_o (mgr_write),
      .mgr_addr_o  (mgr_addr),
      .mgr_wdata_o (mgr_wdata),
      .mgr_wstrb_o (mgr_wstrb),
      .mgr_rdata_i (mgr_rdata),
      .mgr_ready_i (mgr_ready),
      .mgr_error_i (mgr_error),
      .timeout_o   (timeout),
      .state_o     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_write = '0;
      req_wdata = '0;
      req_wstrb = '0;
      mgr_rdata = '0;
      mgr_ready = 1'b0;
      mgr_error = 1'b0;
      for (int i = 0; i < 4; i++) req_addr[i] = 32'h100 + 32'(4 * i);

      // Reset state
      @(negedge clk);
      #1;
      chk("rst_state", 64'(state), 64'(IDLE));
      chk("rst_mgr_valid", 64'(mgr_valid), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_timeout", 64'(timeout), 64'd0);
      rst_n = 1'b1;

      // Fairness: all valid, zero-wait target -> 0,1,2,3,0 every 2 cycles
      req_valid = 4'b1111;
      mgr_ready = 1'b1;
      #1;
      chk("fair_idle_ready_ignored", 64'(req_ready), 64'd0);
      for (int k = 0; k < 5; k++) begin
         step();
         #1;
         chk("fair_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
         chk("fair_addr", 64'(mgr_addr), 64'(32'h100 + 32'(4 * (k % 4))));
         step();
         #1;
         chk("fair_gap_valid", 64'(mgr_valid), 64'd0);
      end
      req_valid = '0;
      mgr_ready = 1'b0;

      // Single read from requester 2 (ptr now 1)
      req_addr[2]  = 32'h10;
      req_valid[2] = 1'b1;
      #1;
      chk("single_valid_n", 64'(mgr_valid), 64'd0);
      step();
      #1;
      chk("single_valid_n1", 64'(mgr_valid), 64'd1);
      chk("single_addr", 64'(mgr_addr), 64'h10);
      chk("single_write", 64'(mgr_write), 64'd0);
      chk("single_state", 64'(state), 64'(BUSY));
      step();
      #1;
      chk("single_wait_ready", 64'(req_ready), 64'd0);
      step();
      mgr_ready = 1'b1;
      mgr_rdata = 32'hDEADBEEF;
      #1;
      chk("single_ready", 64'(req_ready), 64'b0100);
      chk("single_rdata2", 64'(req_rdata[2]), 64'hDEADBEEF);
      chk("single_rdata0", 64'(req_rdata[0]), 64'd0);
      chk("single_error", 64'(req_error), 64'd0);
      step();
      mgr_ready = 1'b0;
      mgr_rdata = '0;

      // Wrap-around: ptr=3, requesters 0 and 3 valid -> 3 first
      req_valid = 4'b1001;
      #1;
      chk("wrap_idle", 64'(mgr_valid), 64'd0);
      step();
      #1;
      chk("wrap_first_addr", 64'(mgr_addr), 64'h10C);
      mgr_ready = 1'b1;
      #1;
      chk("wrap_first_ready", 64'(req_ready), 64'b1000);
      step();
      req_valid = 4'b0001;
      mgr_ready = 1'b0;
      step();
      #1;
      chk("wrap_second_addr", 64'(mgr_addr), 64'h100);
      mgr_ready = 1'b1;
      #1;
      chk("wrap_second_ready", 64'(req_ready), 64'b0001);
      step();
      req_valid = '0;
      mgr_ready = 1'b0;

      // Error pass-through on a write from requester 1 (ptr=1)
      req_valid    = 4'b1010;
      req_write[1] = 1'b1;
      req_wdata[1] = 32'hCAFE0001;
      req_wstrb[1] = 4'h3;
      step();
      #1;
      chk("err_addr", 64'(mgr_addr), 64'h104);
      chk("err_write", 64'(mgr_write), 64'd1);
      chk("err_wdata", 64'(mgr_wdata), 64'hCAFE0001);
      chk("err_wstrb", 64'(mgr_wstrb), 64'h3);
      mgr_ready = 1'b1;
      mgr_error = 1'b1;
      mgr_rdata = 32'h12345678;
      #1;
      chk("err_ready", 64'(req_ready), 64'b0010);
      chk("err_error", 64'(req_error), 64'b0010);
      chk("err_write_rdata", 64'(req_rdata[1]), 64'd0);
      chk("err_other_rdata", 64'(req_rdata[3]), 64'd0);
      step();
      mgr_ready    = 1'b0;
      mgr_error    = 1'b0;
      mgr_rdata    = 32'h55AA55AA;
      req_write[1] = 1'b0;
      req_valid    = 4'b1001;

      // Stalled target on requester 3 (ptr=2)
      step();
      for (int c = 1; c < 8; c++) begin
         #1;
         chk("wd_busy_valid", 64'(mgr_valid), 64'd1);
         chk("wd_busy_ready", 64'(req_ready), 64'd0);
         chk("wd_busy_timeout", 64'(timeout), 64'd0);
         step();
      end
      #1;
`ifdef REG_BUS_RR_ARBITER_TIMEOUT_EN
      chk("wd_abort_valid", 64'(mgr_valid), 64'd0);
      chk("wd_abort_ready", 64'(req_ready), 64'b1000);
      chk("wd_abort_error", 64'(req_error), 64'b1000);
      chk("wd_abort_rdata", 64'(req_rdata[3]), 64'd0);
      chk("wd_abort_timeout", 64'(timeout), 64'd1);
      step();
      #1;
      chk("wd_pulse_once", 64'(timeout), 64'd0);
      chk("wd_after_state", 64'(state), 64'(IDLE));
      req_valid = 4'b0001;
`else
      chk("wd_off_valid", 64'(mgr_valid), 64'd1);
      chk("wd_off_ready", 64'(req_ready), 64'd0);
      chk("wd_off_timeout", 64'(timeout), 64'd0);
      step();
      #1;
      chk("wd_off_state", 64'(state), 64'(BUSY));
      mgr_ready = 1'b1;
      #1;
      chk("wd_off_ready_late", 64'(req_ready), 64'b1000);
      chk("wd_off_rdata", 64'(req_rdata[3]), 64'h55AA55AA);
      step();
      mgr_ready = 1'b0;
      req_valid = 4'b0001;
`endif
      step();
      #1;
      chk("wd_next_state", 64'(state), 64'(BUSY));
      chk("wd_next_addr", 64'(mgr_addr), 64'h100);
      mgr_ready = 1'b1;
      #1;
      chk("wd_next_ready", 64'(req_ready), 64'b0001);
      step();
      mgr_ready = 1'b0;
      req_valid = 4'b0100;

      // Reset in the middle of an access to requester 2 (ptr=1)
      step();
      #1;
      chk("rstmid_pre_addr", 64'(mgr_addr), 64'h10);
      rst_n     = 1'b0;
      mgr_ready = 1'b1;
      #1;
      chk("rstmid_valid", 64'(mgr_valid), 64'd0);
      chk("rstmid_addr", 64'(mgr_addr), 64'd0);
      chk("rstmid_ready", 64'(req_ready), 64'd0);
      chk("rstmid_state", 64'(state), 64'(IDLE));
      step();
      rst_n     = 1'b1;
      mgr_ready = 1'b0;
      req_valid = 4'b0111;
      #1;
      chk("rstmid_release_valid", 64'(mgr_valid), 64'd0);
      step();
      #1;
      chk("rstmid_first_grant", 64'(mgr_addr), 64'h100);
      chk("rstmid_first_valid", 64'(mgr_valid), 64'd1);

      // Requester withdraws while BUSY: valid falls, no response
      req_valid = 4'b0110;
      #1;
      chk("withdraw_valid", 64'(mgr_valid), 64'd0);
      chk("withdraw_ready", 64'(req_ready), 64'd0);
      step();
      #1;
      chk("withdraw_state", 64'(state), 64'(IDLE));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
